// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: eight-way round-robin arbiter releasing on ack, withdraw or timeout.
// Ports: clk_i, rst_n_i (async, low); req_0_i..req_7_i requests; ack_i grant done;
//        grant_0_o..grant_7_o one-hot grant; grant_valid_o any grant; timeout_o release pulse.
module rr_arbiter_8 #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic req_0_i,
   input  logic req_1_i,
   input  logic req_2_i,
   input  logic req_3_i,
   input  logic req_4_i,
   input  logic req_5_i,
   input  logic req_6_i,
   input  logic req_7_i,
   input  logic ack_i,
   output logic grant_0_o,
   output logic grant_1_o,
   output logic grant_2_o,
   output logic grant_3_o,
   output logic grant_4_o,
   output logic grant_5_o,
   output logic grant_6_o,
   output logic grant_7_o,
   output logic grant_valid_o,
   output logic timeout_o
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;
   localparam logic [7:0] HOLD_MAX = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] req;
   logic [7:0] grant_q;
   logic [0:0] state_q;
   logic [2:0] ptr_q;
   logic [2:0] idx_q;
   logic [7:0] hold_q;
   logic       valid_q;
   logic       timeout_q;
   logic [2:0] sel_idx;
   logic       sel_hit;
   logic       hit_max;
   logic       withdraw;
   logic       release_g;

   assign req = {req_7_i, req_6_i, req_5_i, req_4_i,
                 req_3_i, req_2_i, req_1_i, req_0_i};

   // First requester at or above ptr; the 3-bit add wraps 7 -> 0.
   always_comb begin
      sel_hit = 1'b0;
      sel_idx = ptr_q;
      for (int i = 0; i < 8; i++) begin
         if (!sel_hit && req[ptr_q + 3'(i)]) begin
            sel_hit = 1'b1;
            sel_idx = ptr_q + 3'(i);
         end
      end
   end

   assign hit_max   = (hold_q == HOLD_MAX);
   assign withdraw  = !req[idx_q];
   assign release_g = ack_i || withdraw || hit_max;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         ptr_q     <= '0;
         idx_q     <= '0;
         hold_q    <= '0;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (sel_hit) begin
                  state_q <= GRANT;
                  idx_q   <= sel_idx;
                  grant_q <= 8'b1 << sel_idx;
                  valid_q <= 1'b1;
                  hold_q  <= '0;
               end
            end
            GRANT: begin
               if (release_g) begin
                  state_q   <= IDLE;
                  grant_q   <= '0;
                  valid_q   <= 1'b0;
                  hold_q    <= '0;
                  ptr_q     <= idx_q + 3'd1;
                  // ack or withdraw on the last cycle wins over timeout
                  timeout_q <= hit_max && !ack_i && !withdraw;
               end else begin
                  hold_q <= hold_q + 8'd1;
               end
            end
         endcase
      end
   end

   assign grant_0_o     = grant_q[0];
   assign grant_1_o     = grant_q[1];
   assign grant_2_o     = grant_q[2];
   assign grant_3_o     = grant_q[3];
   assign grant_4_o     = grant_q[4];
   assign grant_5_o     = grant_q[5];
   assign grant_6_o     = grant_q[6];
   assign grant_7_o     = grant_q[7];
   assign grant_valid_o = valid_q;
   assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: directed stimulus for rr_arbiter_8 with a queued scoreboard.
// Expected grant/timeout cycles are pushed by stimulus and popped by the monitor.
module tb_rr_arbiter_8;

   typedef struct {
      int         cyc;
      logic [7:0] g;
      logic       to;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] req = 8'h00;
   logic       ack = 1'b0;
   logic [7:0] g;
   logic       gv;
   logic       to;

   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   exp_t q[$];

   rr_arbiter_8 #(.TIMEOUT_CYCLES(4)) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .req_0_i      (req[0]),
      .req_1_i      (req[1]),
      .req_2_i      (req[2]),
      .req_3_i      (req[3]),
      .req_4_i      (req[4]),
      .req_5_i      (req[5]),
      .req_6_i      (req[6]),
      .req_7_i      (req[7]),
      .ack_i        (ack),
      .grant_0_o    (g[0]),
      .grant_1_o    (g[1]),
      .grant_2_o    (g[2]),
      .grant_3_o    (g[3]),
      .grant_4_o    (g[4]),
      .grant_5_o    (g[5]),
      .grant_6_o    (g[6]),
      .grant_7_o    (g[7]),
      .grant_valid_o(gv),
      .timeout_o    (to)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic push(input int c, input logic [7:0] eg, input logic et);
      exp_t e;
      e.cyc = c;
      e.g   = eg;
      e.to  = et;
      q.push_back(e);
   endtask

   task automatic chk_zero(input string name);
      total++;
      if (g !== 8'h00 || gv !== 1'b0 || to !== 1'b0) begin
         bad++;
         $display("FAIL %s: got g=%h gv=%b to=%b, want all 0",
                  name, g, gv, to);
      end
   endtask

   // Grant appears next cycle, ack on its second cycle, then one idle cycle.
   task automatic ack_grant(input logic [7:0] eg);
      push(cyc + 1, eg, 1'b0);
      push(cyc + 2, eg, 1'b0);
      @(negedge clk);
      @(negedge clk);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
   endtask

   // Monitor: structural check every cycle, scoreboard pop on any output event.
   always @(negedge clk) begin
      if (rst_n) begin
         total++;
         if (!$onehot0(g) || gv !== (g != 8'h00)) begin
            bad++;
            $display("FAIL onehot: got g=%h gv=%b, want one-hot with matching valid",
                     g, gv);
         end
         if (gv || to) begin
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL unexpected: got cyc=%0d g=%h to=%b, want no output",
                        cyc, g, to);
            end else begin
               exp_t e;
               e = q.pop_front();
               if (e.cyc != cyc || e.g !== g || e.to !== to) begin
                  bad++;
                  $display("FAIL event: got cyc=%0d g=%h to=%b, want cyc=%0d g=%h to=%b",
                           cyc, g, to, e.cyc, e.g, e.to);
               end
            end
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      // reset with all requests high
      req = 8'hFF;
      repeat (3) @(negedge clk);
      chk_zero("reset_hold");
      rst_n = 1'b1;
      // full rotation 0..7,0 with one idle cycle between grants
      for (int k = 0; k < 9; k++) ack_grant(8'h01 << (k % 8));
      // ack while idle with no requests does nothing
      req = 8'h00;
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      @(negedge clk);
      // single requester 5, repeats every 3 cycles
      req = 8'h20;
      for (int k = 0; k < 3; k++) ack_grant(8'h20);
      req = 8'h00;
      @(negedge clk);
      // timeout on 2 then 3, no ack
      req = 8'h0C;
      c = cyc;
      for (int k = 1; k <= 4; k++) push(c + k, 8'h04, 1'b0);
      push(c + 5, 8'h00, 1'b1);
      for (int k = 6; k <= 9; k++) push(c + k, 8'h08, 1'b0);
      push(c + 10, 8'h00, 1'b1);
      repeat (10) @(negedge clk);
      req = 8'h00;
      @(negedge clk);
      // ack on the timeout cycle: no timeout pulse
      req = 8'h01;
      c = cyc;
      for (int k = 1; k <= 4; k++) push(c + k, 8'h01, 1'b0);
      repeat (4) @(negedge clk);
      ack = 1'b1;
      req = 8'h00;
      @(negedge clk);
      ack = 1'b0;
      @(negedge clk);
      // withdraw of req 6 in its second grant cycle
      req = 8'h40;
      c = cyc;
      push(c + 1, 8'h40, 1'b0);
      push(c + 2, 8'h40, 1'b0);
      repeat (2) @(negedge clk);
      req = 8'h00;
      repeat (2) @(negedge clk);
      // async reset mid-grant, then restart from index 0
      req = 8'hFF;
      c = cyc;
      push(c + 1, 8'h80, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_zero("reset_async");
      @(posedge clk);
      #1 chk_zero("reset_edge");
      @(negedge clk);
      rst_n = 1'b1;
      ack_grant(8'h01);
      req = 8'h00;
      repeat (3) @(negedge clk);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
